// File: rtl/jtframe_dwnld_sched_if.sv
// Bus bundle between the download scheduler, the hps_io ioctl byte stream
// and the SDRAM programming port.
//   ioctl_download/index/wr/addr/data : byte stream from hps_io
//   prog_addr/data/mask/ba/we          : word write request towards SDRAM
//   prog_rdy                           : SDRAM has accepted the current write
// modport slave  : the scheduler's view
// modport master : the view of whoever drives the byte stream and answers prog_rdy
interface jtframe_dwnld_sched_if;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_data;
  logic [21:0] prog_addr;
  logic [15:0] prog_data;
  logic [1:0]  prog_mask;
  logic [1:0]  prog_ba;
  logic        prog_we;
  logic        prog_rdy;

  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_data, prog_rdy,
    output prog_addr, prog_data, prog_mask, prog_ba, prog_we
  );

  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_data, prog_rdy,
    input  prog_addr, prog_data, prog_mask, prog_ba, prog_we
  );
endinterface

// File: rtl/jtframe_dwnld_sched.sv
// Download scheduler: packs index-0 ROM bytes into 16-bit words, picks the
// SDRAM bank from the byte address, buffers words in a small FIFO and hands
// them to the SDRAM programming port with a prog_we/prog_rdy handshake.
// Also captures core_mod (index 1) and MRA DIP switches (index 254).
// Ports:
//   clk_rom     : single clock
//   rst         : asynchronous, active-high reset
//   bus         : ioctl byte stream in, prog_* word writes out (slave modport)
//   downloading : ROM stream window active (LOAD)
//   dwnld_busy  : any non-idle state (LOAD, FLUSH, DRAIN)
//   overflow    : sticky, a word or byte was lost
//   core_mod    : core mode bits
//   dipsw       : MRA DIP switches, byte 0 in [7:0]
module jtframe_dwnld_sched #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [24:0] BA1_START  = 25'h10_0000,
  parameter logic [24:0] BA2_START  = 25'h18_0000,
  parameter logic [24:0] BA3_START  = 25'h1C_0000
) (
  input  logic                    clk_rom,
  input  logic                    rst,
  jtframe_dwnld_sched_if.slave    bus,
  output logic                    downloading,
  output logic                    dwnld_busy,
  output logic                    overflow,
  output logic [6:0]              core_mod,
  output logic [31:0]             dipsw
);

  localparam int           AW   = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]  FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

  // Field order matches the {ba, addr, data, mask} load of the prog_* port.
  typedef struct packed {
    logic [1:0]  ba;
    logic [21:0] addr;
    logic [15:0] data;
    logic [1:0]  mask;
  } word_t;

  state_t          state, state_nx;
  word_t           mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            pend_valid;
  logic [24:0]     pend_addr;
  logic [7:0]      pend_byte;
  logic            st_push;      // a packed word waits one cycle before entering the FIFO
  word_t           st_word;
  logic            pop, push_ok, wr_rom;

  // Bank and in-bank word address for a word whose even byte sits at a.
  function automatic word_t make_word(input logic [24:0] a, input logic [15:0] d,
                                      input logic [1:0] m);
    word_t       w;
    logic [24:0] start;
    if (a >= BA3_START)      begin w.ba = 2'd3; start = BA3_START; end
    else if (a >= BA2_START) begin w.ba = 2'd2; start = BA2_START; end
    else if (a >= BA1_START) begin w.ba = 2'd1; start = BA1_START; end
    else                     begin w.ba = 2'd0; start = '0;        end
    w.addr = 22'((a - start) >> 1);
    w.data = d;
    w.mask = m;
    return w;
  endfunction

  assign pop     = bus.prog_we && bus.prog_rdy;
  // A full FIFO still accepts the word when the head leaves on the same edge.
  assign push_ok = st_push && (count != FULL || pop);
  assign wr_rom  = bus.ioctl_wr && bus.ioctl_index == 8'd0;

  // NOTE: every variable assigned in a combinational block gets a default
  // first, otherwise paths that skip the assignment infer a latch.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (bus.ioctl_download && bus.ioctl_index == 8'd0) state_nx = LOAD;
      LOAD:  if (!bus.ioctl_download) state_nx = FLUSH;
      FLUSH: state_nx = DRAIN;
      DRAIN: if (count == '0 && !bus.prog_we && !st_push) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: the FIFO storage is deliberately left out of reset; the pointers
  // and count define what is valid, so clearing the array buys nothing.
  always_ff @(posedge clk_rom) begin
    if (push_ok) mem[wr_ptr] <= st_word;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // read in this block sees the value from before the clock edge.
  always_ff @(posedge clk_rom or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      downloading   <= 1'b0;
      dwnld_busy    <= 1'b0;
      overflow      <= 1'b0;
      core_mod      <= 7'b000_0001;
      dipsw         <= 32'hFFFF_FFFF;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      pend_valid    <= 1'b0;
      pend_addr     <= '0;
      pend_byte     <= '0;
      st_push       <= 1'b0;
      st_word       <= '0;
      bus.prog_we   <= 1'b0;
      bus.prog_addr <= '0;
      bus.prog_data <= '0;
      bus.prog_mask <= 2'b11;
      bus.prog_ba   <= '0;
    end else begin
      state       <= state_nx;
      downloading <= state_nx == LOAD;
      dwnld_busy  <= state_nx != IDLE;
      st_push     <= 1'b0;

      // FIFO bookkeeping; a word that cannot be stored is dropped and flagged
      if (push_ok)      wr_ptr   <= wr_ptr + 1'b1;
      else if (st_push) overflow <= 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase

      // Port: the head stays in the count while presented; the pop edge drops
      // prog_we, which guarantees an idle cycle before the next word.
      if (pop) begin
        bus.prog_we <= 1'b0;
      end else if (!bus.prog_we && count != '0) begin
        bus.prog_we <= 1'b1;
        {bus.prog_ba, bus.prog_addr, bus.prog_data, bus.prog_mask} <= mem[rd_ptr];
      end

      if (state == IDLE && state_nx == LOAD) begin
        overflow   <= 1'b0;
        pend_valid <= 1'b0;
      end

      // Byte packing
      if (wr_rom) begin
        if (state != LOAD) begin
          overflow <= 1'b1;
        end else if (!bus.ioctl_addr[0]) begin
          if (pend_valid) begin
            st_push <= 1'b1;
            st_word <= make_word(pend_addr, {8'h00, pend_byte}, 2'b10);
          end
          pend_valid <= 1'b1;
          pend_addr  <= bus.ioctl_addr;
          pend_byte  <= bus.ioctl_data;
        end else if (pend_valid && pend_addr[24:1] == bus.ioctl_addr[24:1]) begin
          st_push    <= 1'b1;
          st_word    <= make_word(pend_addr, {bus.ioctl_data, pend_byte}, 2'b00);
          pend_valid <= 1'b0;
        end else begin
          // Lone odd byte; an unrelated pending byte stays held for later
          st_push <= 1'b1;
          st_word <= make_word({bus.ioctl_addr[24:1], 1'b0}, {bus.ioctl_data, 8'h00}, 2'b01);
        end
      end

      if (state == FLUSH && pend_valid) begin
        st_push    <= 1'b1;
        st_word    <= make_word(pend_addr, {8'h00, pend_byte}, 2'b10);
        pend_valid <= 1'b0;
      end

      // Side-band captures, accepted in any state
      if (bus.ioctl_wr && bus.ioctl_index == 8'd1 && bus.ioctl_addr == '0)
        core_mod <= bus.ioctl_data[6:0];
      if (bus.ioctl_wr && bus.ioctl_index == 8'd254 && bus.ioctl_addr[24:2] == '0)
        dipsw[{bus.ioctl_addr[1:0], 3'b000} +: 8] <= bus.ioctl_data;
    end
  end

endmodule

// File: tb/tb_jtframe_dwnld_sched.sv
// Testbench for jtframe_dwnld_sched: directed byte streams, a queue of
// expected SDRAM writes filled by the stimulus and drained by a monitor that
// compares each write as the DUT presents it.
module tb_jtframe_dwnld_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        downloading, dwnld_busy, overflow;
  logic [6:0]  core_mod;
  logic [31:0] dipsw;

  jtframe_dwnld_sched_if bus();

  jtframe_dwnld_sched dut (
    .clk_rom     (clk),
    .rst         (rst),
    .bus         (bus),
    .downloading (downloading),
    .dwnld_busy  (dwnld_busy),
    .overflow    (overflow),
    .core_mod    (core_mod),
    .dipsw       (dipsw)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  int          n_writes = 0;
  int          rdy_delay = 3;
  bit          rdy_hold  = 1'b0;
  logic [41:0] exp_q[$];   // {ba, addr, data, mask}

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [41:0] wexp(input logic [1:0] ba, input logic [21:0] a,
                                       input logic [15:0] d, input logic [1:0] m);
    return {ba, a, d, m};
  endfunction

  // Monitor: each new presentation pops one expected write; while prog_we
  // stays high the presented word must not change.
  initial begin : monitor
    logic        prev_we = 1'b0;
    logic [41:0] held = '0;
    logic [41:0] cur;
    forever begin
      @(negedge clk);
      cur = {bus.prog_ba, bus.prog_addr, bus.prog_data, bus.prog_mask};
      if (rst) begin
        prev_we = 1'b0;
      end else begin
        if (bus.prog_we && !prev_we) begin
          n_writes++;
          held = cur;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write actual=%h required=none", cur);
          end else begin
            check("write", 64'(cur), 64'(exp_q.pop_front()));
          end
        end else if (bus.prog_we) begin
          check("hold_stable", 64'(cur), 64'(held));
        end
        prev_we = bus.prog_we;
      end
    end
  end

  // SDRAM model: answers prog_rdy rdy_delay cycles after a word appears.
  initial begin : responder
    int wait_cnt = 0;
    bus.prog_rdy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst || !bus.prog_we) begin
        bus.prog_rdy = 1'b0;
        wait_cnt = 0;
      end else if (!rdy_hold) begin
        if (wait_cnt >= rdy_delay) bus.prog_rdy = 1'b1;
        else wait_cnt++;
      end
    end
  end

  task automatic wr_byte(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.ioctl_wr = 1'b1; bus.ioctl_index = idx; bus.ioctl_addr = a; bus.ioctl_data = d;
    @(negedge clk);
    bus.ioctl_wr = 1'b0;
  endtask

  task automatic open_window();
    @(negedge clk);
    bus.ioctl_index = 8'd0; bus.ioctl_download = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic close_and_drain(input string name);
    int n = 0;
    bus.ioctl_download = 1'b0;
    while (dwnld_busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({name, "_busy_timeout"}, 64'(dwnld_busy), 64'(0));
    check({name, "_drained"}, 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    int w0;
    bus.ioctl_download = 1'b0; bus.ioctl_index = 8'd0; bus.ioctl_wr = 1'b0;
    bus.ioctl_addr = '0; bus.ioctl_data = '0;
    repeat (3) @(negedge clk);
    check("rst_prog_we",   64'(bus.prog_we),   64'(0));
    check("rst_prog_mask", 64'(bus.prog_mask), 64'(2'b11));
    check("rst_core_mod",  64'(core_mod),      64'(7'h01));
    check("rst_dipsw",     64'(dipsw),         64'(32'hFFFF_FFFF));
    check("rst_busy",      64'({downloading, dwnld_busy, overflow}), 64'(0));
    rst = 1'b0;

    // Single word and its timing
    open_window();
    check("load_flags", 64'({downloading, dwnld_busy}), 64'(2'b11));
    exp_q.push_back(wexp(2'd0, 22'h0, 16'h2211, 2'b00));
    wr_byte(8'd0, 25'h0, 8'h11);
    wr_byte(8'd0, 25'h1, 8'h22);
    @(negedge clk);
    check("we_n_plus_1", 64'(bus.prog_we), 64'(0));
    @(negedge clk);
    check("we_n_plus_2", 64'(bus.prog_we), 64'(1));
    repeat (3) @(negedge clk);
    check("we_held_until_rdy", 64'(bus.prog_we), 64'(1));

    // Bank mapping, trailing byte flushed on close
    exp_q.push_back(wexp(2'd1, 22'h2, 16'hBBAA, 2'b00));
    exp_q.push_back(wexp(2'd3, 22'h0, 16'h00CC, 2'b10));
    wr_byte(8'd0, 25'h10_0004, 8'hAA);
    wr_byte(8'd0, 25'h10_0005, 8'hBB);
    wr_byte(8'd0, 25'h1C_0000, 8'hCC);
    bus.ioctl_download = 1'b0;
    @(negedge clk);
    check("downloading_fall", 64'({downloading, dwnld_busy}), 64'(2'b01));
    close_and_drain("banks");

    // Three bytes: second word carries the lone even byte
    open_window();
    exp_q.push_back(wexp(2'd0, 22'h0, 16'h2211, 2'b00));
    exp_q.push_back(wexp(2'd0, 22'h1, 16'h0033, 2'b10));
    w0 = n_writes;
    wr_byte(8'd0, 25'h0, 8'h11);
    wr_byte(8'd0, 25'h1, 8'h22);
    wr_byte(8'd0, 25'h2, 8'h33);
    close_and_drain("flush");
    check("flush_writes", 64'(n_writes - w0), 64'(2));
    check("no_overflow", 64'(overflow), 64'(0));

    // ROM byte outside a window is discarded
    wr_byte(8'd0, 25'h4, 8'h44);
    repeat (3) @(negedge clk);
    check("idle_byte_overflow", 64'(overflow), 64'(1));
    check("idle_byte_no_busy", 64'(dwnld_busy), 64'(0));

    // FIFO overflow with the port stalled
    rdy_hold = 1'b1;
    open_window();
    check("entry_clears_overflow", 64'(overflow), 64'(0));
    w0 = n_writes;
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 1 && i < 8)
        exp_q.push_back(wexp(2'd0, 22'(i / 2), {8'(8'h10 + i), 8'(8'h10 + i - 1)}, 2'b00));
      wr_byte(8'd0, 25'(i), 8'(8'h10 + i));
    end
    repeat (3) @(negedge clk);
    check("fifo_overflow", 64'(overflow), 64'(1));
    rdy_hold = 1'b0;
    close_and_drain("overflow");
    check("overflow_writes", 64'(n_writes - w0), 64'(4));

    // Side-band captures
    wr_byte(8'd254, 25'h2, 8'h5A);
    @(negedge clk);
    check("dipsw_byte2", 64'(dipsw), 64'(32'hFF5A_FFFF));
    wr_byte(8'd1, 25'h0, 8'h83);
    @(negedge clk);
    check("core_mod_set", 64'(core_mod), 64'(7'h03));
    wr_byte(8'd1, 25'h1, 8'h55);
    @(negedge clk);
    check("core_mod_addr1", 64'(core_mod), 64'(7'h03));

    // Reset in the middle of a held write
    rdy_hold = 1'b1;
    open_window();
    exp_q.push_back(wexp(2'd0, 22'h0, 16'h6655, 2'b00));
    wr_byte(8'd0, 25'h0, 8'h55);
    wr_byte(8'd0, 25'h1, 8'h66);
    repeat (3) @(negedge clk);
    check("pre_reset_we", 64'(bus.prog_we), 64'(1));
    #2 rst = 1'b1;
    #1;
    check("reset_drops_we", 64'(bus.prog_we), 64'(0));
    check("reset_core_mod", 64'(core_mod), 64'(7'h01));
    check("reset_dipsw",    64'(dipsw),    64'(32'hFFFF_FFFF));
    check("reset_busy",     64'({downloading, dwnld_busy}), 64'(0));
    exp_q.delete();
    bus.ioctl_download = 1'b0;
    rdy_hold = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("after_reset_quiet", 64'(bus.prog_we), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
